seg_display_mux: RTL and testbench

Parametrised multiplexed 7-segment display driver: scans NUM_DIGITS hex digits, one slot per refresh tick.
Adds double-buffered frame-synchronous loading with ack, 16-level PWM brightness, per-digit blank/blink/DP, and leading-zero suppression.
Selectable output polarities.
Sits between status/datapath logic and board anode/cathode pins.

---
 rtl/seg_display_mux.sv | 249 ++++++++++++++++++++++++
 tb/tb_seg_display_mux.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_mux.sv
// Multiplexed 7-segment driver: scans NUM_DIGITS hex digits with frame-synchronous
// double-buffered loading, 16-level PWM brightness, blank/blink/DP and leading-zero suppression.
module seg_display_mux #(
  parameter int NUM_DIGITS       = 8,
  parameter int CLK_DIV          = 250000,
  parameter int BLINK_FRAMES     = 100,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blank_in,
  input  logic [NUM_DIGITS-1:0]     blink_in,
  input  logic                      lz_suppress,
  input  logic [3:0]                brightness,
  input  logic                      load,
  output logic                      load_ack,
  output logic                      frame_start,
  output logic [7:0]                cathode,
  output logic [NUM_DIGITS-1:0]     anode
);

  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SUB  = CLK_DIV / 16;
  localparam int SUBW = (SUB > 1) ? $clog2(SUB) : 1;
  localparam int IDXW = $clog2(NUM_DIGITS);
  localparam int FRW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
  localparam logic [SUBW-1:0] SUB_LAST = SUBW'(SUB - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_DIGITS - 1);
  localparam logic [FRW-1:0]  FR_LAST  = FRW'(BLINK_FRAMES - 1);

  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
  localparam logic [7:0]            CAT_OFF = {8{SEG_ACTIVE_LOW}};

  // Standard hex map, bits ordered {A,B,C,D,E,F,G}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1111110;
      4'h1:    s = 7'b0110000;
      4'h2:    s = 7'b1101101;
      4'h3:    s = 7'b1111001;
      4'h4:    s = 7'b0110011;
      4'h5:    s = 7'b1011011;
      4'h6:    s = 7'b1011111;
      4'h7:    s = 7'b1110000;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1111011;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b0011111;
      4'hC:    s = 7'b1001110;
      4'hD:    s = 7'b0111101;
      4'hE:    s = 7'b1001111;
      4'hF:    s = 7'b1000111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  logic [DIVW-1:0]         div_q,   div_d;
  logic [SUBW-1:0]         sub_q,   sub_d;
  logic [3:0]              phase_q, phase_d;
  logic [IDXW-1:0]         idx_q,   idx_d;
  logic [FRW-1:0]          frame_q, frame_d;
  logic                    blink_ph_q, blink_ph_d;
  logic                    pending_q,  pending_d;

  logic [4*NUM_DIGITS-1:0] sh_digits_q;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_blank_q, sh_blink_q;
  logic [4*NUM_DIGITS-1:0] act_digits_q;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_blank_q, act_blink_q;

  logic                    load_ack_q, load_ack_d;
  logic                    frame_start_q, frame_start_d;
  logic [7:0]              cathode_q, cathode_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;

  logic                    tick_s, wrap_s, commit_s;
  logic [NUM_DIGITS-1:0]   sup_s;
  logic                    zero_run_s;
  logic [3:0]              cur_digit_s;
  logic                    vis_s;
  logic [NUM_DIGITS-1:0]   anode_raw_s;
  logic [7:0]              cathode_raw_s;

  assign tick_s   = (div_q == DIV_LAST);
  assign wrap_s   = tick_s && (idx_q == IDX_LAST);
  assign commit_s = wrap_s && pending_q;

  // Slot timer, PWM phase, digit index and blink frame counter
  always_comb begin
    div_d      = div_q + 1'b1;
    sub_d      = sub_q + 1'b1;
    phase_d    = phase_q;
    idx_d      = idx_q;
    frame_d    = frame_q;
    blink_ph_d = blink_ph_q;
    if (tick_s) begin
      div_d   = '0;
      sub_d   = '0;
      phase_d = 4'd0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else if (sub_q == SUB_LAST) begin
      sub_d   = '0;
      phase_d = phase_q + 4'd1;
    end else begin
      phase_d = phase_q;
    end
    if (wrap_s) begin
      if (frame_q == FR_LAST) begin
        frame_d    = '0;
        blink_ph_d = ~blink_ph_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end else begin
      frame_d = frame_q;
    end
  end

  // A load on the commit cycle keeps pending set so the fresh shadow commits next frame
  always_comb begin
    pending_d = pending_q;
    if (load) begin
      pending_d = 1'b1;
    end else if (wrap_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Leading-zero suppression walks down from the most significant digit
  always_comb begin
    sup_s      = '0;
    zero_run_s = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run_s = zero_run_s && (act_digits_q[4*i +: 4] == 4'd0);
      sup_s[i]   = lz_suppress && zero_run_s;
    end
  end

  // Visibility of the current slot and the polarity-free output patterns
  always_comb begin
    cur_digit_s = act_digits_q[{idx_q, 2'b00} +: 4];
    vis_s = !act_blank_q[idx_q]
         && !(act_blink_q[idx_q] && blink_ph_q)
         && !sup_s[idx_q]
         && (phase_q <= brightness);
    anode_raw_s = '0;
    if (vis_s) begin
      anode_raw_s[idx_q] = 1'b1;
      cathode_raw_s      = {hex_to_seg(cur_digit_s), act_dp_q[idx_q]};
    end else begin
      cathode_raw_s = 8'h00;
    end
    anode_d       = anode_raw_s ^ AN_OFF;
    cathode_d     = cathode_raw_s ^ CAT_OFF;
    load_ack_d    = commit_s;
    frame_start_d = wrap_s;
  end

  // Scan timing state
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q      <= '0;
      sub_q      <= '0;
      phase_q    <= 4'd0;
      idx_q      <= '0;
      frame_q    <= '0;
      blink_ph_q <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      div_q      <= div_d;
      sub_q      <= sub_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      blink_ph_q <= blink_ph_d;
      pending_q  <= pending_d;
    end
  end

  // Shadow and active display sets; active blank resets to all ones so the display stays dark
  always_ff @(posedge clk) begin
    if (!reset) begin
      sh_digits_q  <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '0;
      sh_blink_q   <= '0;
      act_digits_q <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '1;
      act_blink_q  <= '0;
    end else begin
      if (load) begin
        sh_digits_q <= digits_in;
        sh_dp_q     <= dp_in;
        sh_blank_q  <= blank_in;
        sh_blink_q  <= blink_in;
      end else begin
        sh_digits_q <= sh_digits_q;
        sh_dp_q     <= sh_dp_q;
        sh_blank_q  <= sh_blank_q;
        sh_blink_q  <= sh_blink_q;
      end
      if (commit_s) begin
        act_digits_q <= sh_digits_q;
        act_dp_q     <= sh_dp_q;
        act_blank_q  <= sh_blank_q;
        act_blink_q  <= sh_blink_q;
      end else begin
        act_digits_q <= act_digits_q;
        act_dp_q     <= act_dp_q;
        act_blank_q  <= act_blank_q;
        act_blink_q  <= act_blink_q;
      end
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk) begin
    if (!reset) begin
      load_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
      anode_q       <= AN_OFF;
      cathode_q     <= CAT_OFF;
    end else begin
      load_ack_q    <= load_ack_d;
      frame_start_q <= frame_start_d;
      anode_q       <= anode_d;
      cathode_q     <= cathode_d;
    end
  end

  assign load_ack    = load_ack_q;
  assign frame_start = frame_start_q;
  assign anode       = anode_q;
  assign cathode     = cathode_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed scoreboard bench for seg_display_mux (4 digits, 32-cycle slots, 2-frame blink).
module tb_seg_display_mux;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] digits_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank_in = 4'h0;
  logic [3:0]  blink_in = 4'h0;
  logic        lz_suppress = 1'b0;
  logic [3:0]  brightness = 4'h0;
  logic        load = 1'b0;
  logic        load_ack;
  logic        frame_start;
  logic [7:0]  cathode;
  logic [3:0]  anode;

  seg_display_mux #(
    .NUM_DIGITS(4), .CLK_DIV(32), .BLINK_FRAMES(2),
    .ANODE_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .blink_in(blink_in), .lz_suppress(lz_suppress),
    .brightness(brightness), .load(load), .load_ack(load_ack),
    .frame_start(frame_start), .cathode(cathode), .anode(anode)
  );

  always #5 clk = ~clk;

  int          whenq[$];
  logic [13:0] expq[$];
  string       tagq[$];
  int          ecnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_fail = 0;

  // Expected word is {load_ack, frame_start, anode, cathode} seen after edge 'when'
  task automatic push(input int when, input string tag, input logic ack, input logic fs,
                      input logic [11:0] ac);
    whenq.push_back(when);
    tagq.push_back(tag);
    expq.push_back({ack, fs, ac});
  endtask

  task automatic cyc();
    logic [13:0] obs;
    logic [13:0] ex;
    string       tg;
    @(posedge clk);
    ecnt = ecnt + 1;
    @(negedge clk);
    while (whenq.size() > 0 && whenq[0] <= ecnt) begin
      void'(whenq.pop_front());
      ex  = expq.pop_front();
      tg  = tagq.pop_front();
      obs = {load_ack, frame_start, anode, cathode};
      n_checks = n_checks + 1;
      assert (obs === ex) n_pass = n_pass + 1;
      else begin
        n_fail = n_fail + 1;
        $error("FAIL %s edge %0d: observed ack/fs/anode/cathode=%h required %h", tg, ecnt, obs, ex);
      end
    end
  endtask

  // {anode, cathode} for slot s of the 12AF / dp=0100 pattern
  function automatic logic [11:0] slot_12af(input int s, input bit dark0);
    logic [11:0] r;
    case (s)
      0:       r = dark0 ? 12'hFFF : 12'hE71;
      1:       r = 12'hD11;
      2:       r = 12'hB24;
      3:       r = 12'h79F;
      default: r = 12'hFFF;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] an_of(input int s);
    logic [3:0] r;
    case (s)
      0:       r = 4'hE;
      1:       r = 4'hD;
      2:       r = 4'hB;
      3:       r = 4'h7;
      default: r = 4'hF;
    endcase
    return r;
  endfunction

  initial begin
    int st;
    int s;
    int d;

    repeat (3) @(posedge clk);
    @(negedge clk);
    push(ecnt + 1, "rst_hold", 1'b0, 1'b0, 12'hFFF);
    cyc();
    reset = 1'b1;
    ecnt  = 0;

    // Released without load: dark, frame_start every 128 cycles, no ack
    for (int e = 1; e <= 256; e++) push(e, "t1_dark", 1'b0, (e % 128) == 0, 12'hFFF);
    while (ecnt < 256) cyc();

    // First load of 12AF commits at the next wrap
    digits_in = 16'h12AF; dp_in = 4'b0100; brightness = 4'd15; load = 1'b1;
    cyc();
    load = 1'b0;
    for (int e = 258; e <= 512; e++) begin
      st = e - 1;
      s  = (st / 32) % 4;
      if (e < 384)       push(e, "t2_wait", 1'b0, 1'b0, 12'hFFF);
      else if (e == 384) push(e, "t2_ack", 1'b1, 1'b1, 12'hFFF);
      else               push(e, "t2_frame", 1'b0, e == 512, slot_12af(s, 1'b0));
    end
    while (ecnt < 512) cyc();

    // Brightness 3: lit for phases 0..3 (8 cycles) of each slot
    brightness = 4'd3;
    for (int e = 513; e <= 640; e++) begin
      st = e - 1;
      s  = (st / 32) % 4;
      d  = st % 32;
      push(e, "t3_pwm", 1'b0, e == 640, (d < 8) ? slot_12af(s, 1'b0) : 12'hFFF);
    end
    while (ecnt < 640) cyc();

    // Leading-zero suppression on 0005, then 0000
    brightness = 4'd15; lz_suppress = 1'b1; digits_in = 16'h0005; dp_in = 4'b0000; load = 1'b1;
    cyc();
    load = 1'b0;
    push(768, "t4_ack", 1'b1, 1'b1, 12'h79F);
    for (int e = 769; e <= 896; e++) begin
      s = ((e - 1) / 32) % 4;
      push(e, "t4_frame", 1'b0, e == 896, (s == 0) ? 12'hE49 : 12'hFFF);
    end
    while (ecnt < 896) cyc();
    digits_in = 16'h0000; load = 1'b1;
    cyc();
    load = 1'b0;
    push(1024, "t4_ack0", 1'b1, 1'b1, 12'hFFF);
    for (int e = 1025; e <= 1152; e++) begin
      s = ((e - 1) / 32) % 4;
      push(e, "t4_zero", 1'b0, e == 1152, (s == 0) ? 12'hE03 : 12'hFFF);
    end
    while (ecnt < 1152) cyc();

    // Blink digit 0: dark in frames 2-3 of every 4
    lz_suppress = 1'b0; digits_in = 16'h12AF; dp_in = 4'b0100; blink_in = 4'b0001; load = 1'b1;
    cyc();
    load = 1'b0;
    push(1280, "t5_ack", 1'b1, 1'b1, 12'h703);
    for (int e = 1281; e <= 1792; e++) begin
      st = e - 1;
      s  = (st / 32) % 4;
      push(e, "t5_blink", 1'b0, (e % 128) == 0, slot_12af(s, ((st / 128) % 4) >= 2));
    end
    while (ecnt < 1792) cyc();

    // Load A mid-frame, then load B exactly on the wrap tick
    blink_in = 4'b0000; digits_in = 16'h7777; dp_in = 4'b0000; load = 1'b1;
    cyc();
    load = 1'b0;
    while (ecnt < 1919) cyc();
    digits_in = 16'h8888; load = 1'b1;
    push(1920, "t6_ack1", 1'b1, 1'b1, 12'h79F);
    cyc();
    load = 1'b0;
    for (int e = 1921; e <= 2060; e++) begin
      s = ((e - 1) / 32) % 4;
      if (e < 2048)       push(e, "t6_frmA", 1'b0, 1'b0, {an_of(s), 8'h1F});
      else if (e == 2048) push(e, "t6_ack2", 1'b1, 1'b1, 12'h71F);
      else                push(e, "t6_frmB", 1'b0, 1'b0, {an_of(s), 8'h01});
    end
    while (ecnt < 2060) cyc();

    // Reset mid-slot, then confirm the scan restarts from slot 0
    reset = 1'b0;
    push(ecnt + 1, "t6_rst", 1'b0, 1'b0, 12'hFFF);
    cyc();
    reset = 1'b1;
    ecnt  = 0;
    load  = 1'b1;
    push(1, "t6_rdark", 1'b0, 1'b0, 12'hFFF);
    cyc();
    load = 1'b0;
    for (int e = 2; e <= 160; e++) begin
      if (e < 128)       push(e, "t6_rdark", 1'b0, 1'b0, 12'hFFF);
      else if (e == 128) push(e, "t6_rack", 1'b1, 1'b1, 12'hFFF);
      else               push(e, "t6_rfrm", 1'b0, 1'b0, 12'hE01);
    end
    while (ecnt < 160) cyc();

    n_checks = n_checks + 1;
    assert (whenq.size() == 0) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL sb_drain: observed %0d pending entries required 0", whenq.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
